// File: rtl/frame_buf_pkg.sv
// Shared types and defaults for the ping-pong frame buffer controller.
package frame_buf_pkg;

  // Controller sequencing: wait for first frame, fill first bank, then steady swap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DEPTH  = 1024;

  // Supported read latency of the external bank memory.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to re-time sync and strobe signals.
module sync_delay_line #(
  parameter int DATA_W = 1,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] pipe_p [STAGES];

  // Shift din through STAGES registers; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < STAGES; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[STAGES-1];

endmodule

// File: rtl/frame_pingpong_ctrl.sv
// Ping-pong frame buffer sequencer: one bank written while the other is read,
// banks swap on every vsync rising edge, output video one frame behind input.
module frame_pingpong_ctrl
  import frame_buf_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_vsync,
  input  logic              frame_href,
  input  logic              frame_clken,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [1:0]        bank_valid,
  output logic              overflow,
  output logic              underrun
);

  // Out-of-range latency settings are clamped to the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nx;
  logic              vsync_d;
  logic              vs_rise;
  logic              pix;
  logic              wr_active;
  logic              rd_active;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   rd_len;
  logic [2:0]        sync_p;
  logic              rd_vld_p;

  // Counter value to address, clipped so an address never wraps past DEPTH-1.
  function automatic logic [ADDR_W-1:0] sat_addr(input logic [ADDR_W:0] cnt);
    if (cnt >= DEPTH_C) return ADDR_W'(DEPTH - 1);
    else                return cnt[ADDR_W-1:0];
  endfunction

  assign vs_rise = frame_vsync & ~vsync_d;
  assign pix     = frame_href & frame_clken & ~frame_vsync;

  // Previous vsync for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_d <= 1'b0;
    else        vsync_d <= frame_vsync;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: each frame start advances IDLE -> FILL -> RUN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vs_rise) state_nx = FILL;
      FILL:    if (vs_rise) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: writing from the first frame on, reading only once a bank is full.
  always_comb begin
    wr_active = 1'b0;
    rd_active = 1'b0;
    case (state)
      FILL: wr_active = 1'b1;
      RUN: begin
        wr_active = 1'b1;
        rd_active = 1'b1;
      end
      default: ;
    endcase
  end

  // Bank swap at each frame start: the just-written bank becomes the read bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      bank_valid <= 2'b00;
      rd_len     <= '0;
    end else if (vs_rise) begin
      if (state == IDLE) begin
        wr_bank <= 1'b0;
      end else begin
        bank_valid[wr_bank] <= 1'b1;
        rd_len              <= wr_cnt;
        rd_bank             <= wr_bank;
        wr_bank             <= ~wr_bank;
      end
    end
  end

  // Write strobe/address one cycle after each pixel; excess pixels flag overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (vs_rise) begin
        wr_cnt  <= '0;
        wr_addr <= '0;
      end else if (pix && wr_active) begin
        if (wr_cnt < DEPTH_C) begin
          wr_en   <= 1'b1;
          wr_addr <= sat_addr(wr_cnt);
          wr_cnt  <= wr_cnt + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Read strobe/address one cycle after each pixel; reads past the stored length underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      underrun <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      if (vs_rise) begin
        rd_cnt  <= '0;
        rd_addr <= '0;
      end else if (pix && rd_active) begin
        if (rd_cnt < rd_len) begin
          rd_en   <= 1'b1;
          rd_addr <= sat_addr(rd_cnt);
          rd_cnt  <= rd_cnt + 1'b1;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

  // Sync signals: strobe register stage plus memory read latency.
  sync_delay_line #(
    .DATA_W (3),
    .STAGES (1 + LAT)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({frame_vsync, frame_href, frame_clken}),
    .dout  (sync_p)
  );

  // Read strobe delayed by memory latency marks which output pixels carry valid data.
  sync_delay_line #(
    .DATA_W (1),
    .STAGES (LAT)
  ) u_rd_vld_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rd_en),
    .dout  (rd_vld_p)
  );

  assign post_frame_vsync = sync_p[2];
  assign post_frame_href  = sync_p[1];
  assign post_frame_clken = sync_p[0] & rd_vld_p;

endmodule

// File: tb/tb_frame_pingpong_ctrl.sv
// Directed bench for frame_pingpong_ctrl with DEPTH=1024, RD_LAT=1.
module tb_frame_pingpong_ctrl;
  import frame_buf_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_vsync = 1'b0;
  logic              frame_href = 1'b0;
  logic              frame_clken = 1'b0;
  logic              wr_en, wr_bank, rd_en, rd_bank;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              post_frame_vsync, post_frame_href, post_frame_clken;
  logic [1:0]        bank_valid;
  logic              overflow, underrun;

  int total = 0;
  int bad   = 0;
  bit h_vs, h_hr, en_prev;
  int n;

  frame_pingpong_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_vsync      (frame_vsync),
    .frame_href       (frame_href),
    .frame_clken      (frame_clken),
    .wr_en            (wr_en),
    .wr_bank          (wr_bank),
    .wr_addr          (wr_addr),
    .rd_en            (rd_en),
    .rd_bank          (rd_bank),
    .rd_addr          (rd_addr),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .bank_valid       (bank_valid),
    .overflow         (overflow),
    .underrun         (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},      32'(wr_en), 0);
    chk({tag, "_wr_bank"},    32'(wr_bank), 0);
    chk({tag, "_wr_addr"},    32'(wr_addr), 0);
    chk({tag, "_rd_en"},      32'(rd_en), 0);
    chk({tag, "_rd_bank"},    32'(rd_bank), 0);
    chk({tag, "_rd_addr"},    32'(rd_addr), 0);
    chk({tag, "_pvsync"},     32'(post_frame_vsync), 0);
    chk({tag, "_phref"},      32'(post_frame_href), 0);
    chk({tag, "_pclken"},     32'(post_frame_clken), 0);
    chk({tag, "_bank_valid"}, 32'(bank_valid), 0);
    chk({tag, "_overflow"},   32'(overflow), 0);
    chk({tag, "_underrun"},   32'(underrun), 0);
    chk({tag, "_state"},      32'(dut.state), 32'(IDLE));
  endtask

  // One clock; post sync outputs must equal the inputs driven two edges ago.
  task automatic step(input bit en);
    bit cv, ch;
    cv = frame_vsync;
    ch = frame_href;
    @(posedge clk);
    #1;
    chk("post_vsync", 32'(post_frame_vsync), 32'(h_vs));
    chk("post_href",  32'(post_frame_href),  32'(h_hr));
    chk("post_clken", 32'(post_frame_clken), 32'(en_prev));
    h_vs    = cv;
    h_hr    = ch;
    en_prev = en;
  endtask

  // vsync pulse then npix pixels in lines of 8 with a two-cycle gap.
  task automatic run_frame(input int npix, input bit exp_wrb, input bit exp_rdb,
                           input logic [1:0] exp_bv, input bit rd_on, input int rd_len,
                           output int wr_pulses);
    wr_pulses = 0;
    frame_vsync = 1'b1; frame_href = 1'b0; frame_clken = 1'b0;
    step(1'b0);
    chk("swap_wr_bank",    32'(wr_bank), 32'(exp_wrb));
    chk("swap_rd_bank",    32'(rd_bank), 32'(exp_rdb));
    chk("swap_bank_valid", 32'(bank_valid), 32'(exp_bv));
    chk("swap_wr_addr",    32'(wr_addr), 0);
    chk("swap_rd_addr",    32'(rd_addr), 0);
    step(1'b0);
    chk("vs_hold_wr_bank",    32'(wr_bank), 32'(exp_wrb));
    chk("vs_hold_bank_valid", 32'(bank_valid), 32'(exp_bv));
    frame_vsync = 1'b0;
    step(1'b0);
    step(1'b0);
    for (int k = 0; k < npix; k++) begin
      bit ren;
      int ea;
      frame_href = 1'b1; frame_clken = 1'b1;
      ren = rd_on && (k < rd_len);
      if (!rd_on)        ea = 0;
      else if (ren)      ea = k;
      else if (rd_len>0) ea = rd_len - 1;
      else               ea = 0;
      step(ren);
      chk("wr_en",   32'(wr_en), 32'(k < DEPTH));
      chk("wr_addr", 32'(wr_addr), (k < DEPTH) ? k : DEPTH - 1);
      chk("rd_en",   32'(rd_en), 32'(ren));
      chk("rd_addr", 32'(rd_addr), ea);
      if (wr_en) wr_pulses++;
      if (rd_on) chk("bank_differ", 32'(wr_bank != rd_bank), 1);
      if (k % 8 == 7) begin
        frame_clken = 1'b0;
        step(1'b0);
        chk("gap1_wr_en", 32'(wr_en), 0);
        chk("gap1_rd_en", 32'(rd_en), 0);
        frame_href = 1'b0;
        step(1'b0);
        chk("gap2_wr_en", 32'(wr_en), 0);
        chk("gap2_rd_en", 32'(rd_en), 0);
      end
    end
    frame_href = 1'b0; frame_clken = 1'b0;
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    h_vs = 1'b0; h_hr = 1'b0; en_prev = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Pixels before the first vsync are ignored.
    frame_href = 1'b1; frame_clken = 1'b1;
    repeat (4) begin
      step(1'b0);
      chk("pre_vs_wr_en", 32'(wr_en), 0);
      chk("pre_vs_state", 32'(dut.state), 32'(IDLE));
    end
    frame_href = 1'b0; frame_clken = 1'b0;
    step(1'b0);

    // Frame 1: fill bank 0, no reads.
    run_frame(32, 1'b0, 1'b0, 2'b00, 1'b0, 0, n);
    chk("f1_wr_pulses", n, 32);
    chk("f1_state", 32'(dut.state), 32'(FILL));

    // Frame 2: write bank 1, read bank 0 (32 stored).
    run_frame(32, 1'b1, 1'b0, 2'b01, 1'b1, 32, n);
    chk("f2_wr_pulses", n, 32);
    chk("f2_state", 32'(dut.state), 32'(RUN));
    chk("f2_underrun", 32'(underrun), 0);

    // Frame 3: 40 pixels, read bank 1 (32 stored) -> underrun.
    run_frame(40, 1'b0, 1'b1, 2'b11, 1'b1, 32, n);
    chk("f3_wr_pulses", n, 40);
    chk("f3_underrun", 32'(underrun), 1);
    chk("f3_overflow", 32'(overflow), 0);

    // Frame 4: DEPTH+5 pixels -> overflow, writes stop at DEPTH-1.
    run_frame(DEPTH + 5, 1'b1, 1'b0, 2'b11, 1'b1, 40, n);
    chk("f4_wr_pulses", n, DEPTH);
    chk("f4_wr_addr", 32'(wr_addr), DEPTH - 1);
    chk("f4_overflow", 32'(overflow), 1);

    // Frame 5: 17 pixels then reset mid-frame.
    run_frame(17, 1'b0, 1'b1, 2'b11, 1'b1, DEPTH, n);
    chk("f5_overflow_sticky", 32'(overflow), 1);
    chk("f5_underrun_sticky", 32'(underrun), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    h_vs = 1'b0; h_hr = 1'b0; en_prev = 1'b0;

    // Restart: zero-pixel fill frame in bank 0.
    run_frame(0, 1'b0, 1'b0, 2'b00, 1'b0, 0, n);
    chk("r1_state", 32'(dut.state), 32'(FILL));
    chk("r1_wr_pulses", n, 0);

    // Next frame reads an empty bank: every read underruns.
    run_frame(5, 1'b1, 1'b0, 2'b01, 1'b1, 0, n);
    chk("r2_wr_pulses", n, 5);
    chk("r2_underrun", 32'(underrun), 1);
    chk("r2_overflow", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_pingpong_ctrl.md
Name: frame_pingpong_ctrl

Overview:
Controller that sequences a dual-bank (ping-pong) frame buffer for the eye-tracking video pipeline. It detects frame boundaries from the camera-side sync signals and assigns one bank to the writer and the other to the reader. It generates write and read addresses and strobes, and re-times the sync signals so they stay aligned with the buffer's read data. Output video is exactly one frame behind the input. The bank memories themselves are external.

Parameters:
ADDR_W, 10, pixel address width per bank
DEPTH, 1024, pixels per bank (at most 2**ADDR_W)
RD_LAT, 1, read latency of the external bank memory in clk cycles (1..4)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
frame_vsync  in  1  input vertical sync, active high
frame_href  in  1  input line valid
frame_clken  in  1  input pixel enable
wr_en  out  1  write strobe to bank memory
wr_bank  out  1  bank index being written
wr_addr  out  ADDR_W  write address
rd_en  out  1  read strobe to bank memory
rd_bank  out  1  bank index being read
rd_addr  out  ADDR_W  read address
post_frame_vsync  out  1  vsync aligned to read data
post_frame_href  out  1  href aligned to read data
post_frame_clken  out  1  clken aligned to read data, gated by read validity
bank_valid  out  2  per-bank "holds a complete frame" flags
overflow  out  1  sticky: a frame had more than DEPTH pixels
underrun  out  1  sticky: a read went past the stored frame length

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous, active-low. All outputs and internal registers go to 0. State is IDLE.
- Frame start:
  - vs_rise = frame_vsync & ~vsync_d, where vsync_d is registered frame_vsync.
  - pix = frame_href & frame_clken & ~frame_vsync.
- States:
  - IDLE: on vs_rise, go to FILL. wr_bank = 0, wr_addr = 0.
  - FILL: write only, no reads. On vs_rise:
    - bank_valid[wr_bank] <= 1
    - rd_len <= wr_cnt; rd_bank <= wr_bank
    - wr_bank toggles; counters clear
    - go to RUN
  - RUN: on every vs_rise, do the same swap: rd_bank <= wr_bank, wr_bank <= ~wr_bank, both addresses to 0, rd_len <= wr_cnt, set bank_valid of the just-written bank. Stay in RUN.
- Write path:
  - On pix in FILL or RUN: wr_en = 1 one cycle later (registered), at the current wr_addr.
  - wr_addr then increments; wr_cnt counts pixels (width ADDR_W+1).
  - At wr_cnt == DEPTH, further pix gives no wr_en, wr_addr holds, and overflow is set (sticky).
- Read path (RUN only):
  - On pix: rd_en = 1 one cycle later, at rd_addr; rd_addr increments.
  - If rd_addr >= rd_len: rd_en = 0, rd_addr holds, underrun is set (sticky).
- Latency:
  - Strobes and addresses are registered: 1 cycle after the input.
  - post_frame_vsync/href/clken = the inputs delayed by 1+RD_LAT cycles.
  - post_frame_clken is additionally ANDed with the delayed rd_en, so it is never high during FILL or underrun.
- Priority and boundaries:
  - vs_rise beats pix in the same cycle. pix is masked by vsync anyway.
  - Address wrap never occurs; addresses saturate at DEPTH-1.
  - A zero-pixel frame gives rd_len = 0, and every read in the next frame underruns.
  - Write bank and read bank always differ in RUN.
  - Reset mid-frame aborts immediately to IDLE. bank_valid and the flags clear.
- A vsync that stays high for many cycles produces only one swap.

Decomposition:
- Package frame_buf_pkg:
  - state enum: IDLE, FILL, RUN
  - default DEPTH and ADDR_W
  - RD_LAT bounds
- Sub-module sync_delay_line: parameterised-width, parameterised-depth shift register with async reset. Used for the three post sync signals and the delayed rd_en.

Test Plan:
- Reset then idle inputs -> all outputs 0, state IDLE; pix before the first vsync gives no wr_en.
- Two frames of 8x4 = 32 pixels (DEPTH=1024) -> frame 1 writes bank 0 at addr 0..31 with no rd_en. Frame 2 writes bank 1 and reads bank 0 at addr 0..31. post_frame_clken lags frame_clken by 2 cycles (RD_LAT=1). bank_valid = 2'b01, then 2'b11.
- Three frames -> third frame writes bank 0 and reads bank 1; banks differ every cycle.
- Frame with DEPTH+5 pixels -> wr_addr stops at 1023, exactly 1024 wr_en pulses, overflow = 1 and stays set.
- Frame of 32 pixels followed by a frame of 40 pixels -> reads 32..39 produce no rd_en, post_frame_clken = 0, underrun = 1.
- rst_n low mid-frame in RUN at pixel 17 -> all outputs 0 the same cycle; next vsync restarts in FILL with bank 0.
